// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: elastic inter-stage pipeline register with a two-entry
// skid buffer. The main register drives the outputs, the skid register
// absorbs the one extra entry accepted in the cycle back-pressure appears.
// in_ready and out_valid are flops, so neither depends combinationally on
// out_ready or in_valid. Flush squashes all held entries to bubbles, and a
// saturating counter records the cycles in which the output was stalled.
module pipe_stage_skid #(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    // The encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] STALL_MAX = {CNT_W{1'b1}};

    state_t             state_q, state_d;
    logic [CTRL_W-1:0]  main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0]  main_data_q, main_data_d;
    logic [CTRL_W-1:0]  skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0]  skid_data_q, skid_data_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [CNT_W-1:0]   stall_q, stall_d;

    logic               in_fire;
    logic               out_fire;

    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = out_valid_q & out_ready;

    // Next-state logic for the FIFO control and both payload registers.
    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;

        if (flush) begin
            // Squash everything; any in_valid this cycle is dropped.
            state_d     = EMPTY;
            main_ctrl_d = '0;
            skid_ctrl_d = '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d     = ONE;
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end else if (in_fire) begin
                        // Downstream stalled: park the new entry in the skid.
                        state_d     = FULL;
                        skid_ctrl_d = in_ctrl;
                        skid_data_d = in_data;
                    end else if (out_fire) begin
                        state_d     = EMPTY;
                        main_ctrl_d = '0;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only draining is possible.
                    if (out_fire) begin
                        state_d     = ONE;
                        main_ctrl_d = skid_ctrl_q;
                        main_data_d = skid_data_q;
                        skid_ctrl_d = '0;
                    end
                end
                default: begin
                    state_d     = EMPTY;
                    main_ctrl_d = '0;
                    skid_ctrl_d = '0;
                end
            endcase
        end
    end

    // Handshake flags are precomputed from the next state so they leave flops.
    always_comb begin
        in_ready_d  = (state_d != FULL);
        out_valid_d = (state_d != EMPTY);
    end

    // Saturating stall counter; flush does not touch it.
    always_comb begin
        stall_d = stall_q;
        if (out_valid_q && !out_ready && (stall_q != STALL_MAX)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    // State, payload and counter registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= EMPTY;
            main_ctrl_q <= '0;
            main_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            stall_q     <= '0;
        end else begin
            state_q     <= state_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            stall_q     <= stall_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_ctrl  = main_ctrl_q;
    assign out_data  = main_data_q;
    assign occupancy = state_q;
    assign stall_cnt = stall_q;

endmodule
